// File: rtl/multiword_add_ctrl.sv
// Multi-cycle W=N*K bit adder: one N-bit ripple slice reused over K cycles, LSB slice first.
// Optional subtract mode (s_sub port, B inverted, carry forced to 1) when MWADD_SUB_EN is defined.

module n_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co
);
  logic [N:0] c;

  assign c[0] = ci;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_bit
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign co = c[N];
endmodule

module multiword_add_ctrl #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [N*K-1:0] s_a,
  input  logic [N*K-1:0] s_b,
  input  logic           s_ci,
`ifdef MWADD_SUB_EN
  input  logic           s_sub,
`endif
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N*K-1:0] m_sum,
  output logic           m_co,
  output logic           m_ovf
);
  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, b_reg, sum_reg;
  logic [W-1:0]    sum_shift;
  logic [IW-1:0]   idx_reg;
  logic            carry_reg, a_sign_reg, b_sign_reg;
  logic            s_ready_reg, s_ready_next;
  logic            m_valid_reg, m_valid_next;
  logic            m_co_reg, m_ovf_reg;
  logic            accept, step, last;
  logic [W-1:0]    b_in;
  logic            ci_in;
  logic [N-1:0]    slice_sum;
  logic            slice_co;

`ifdef MWADD_SUB_EN
  assign b_in  = s_sub ? ~s_b : s_b;
  assign ci_in = s_sub | s_ci;
`else
  assign b_in  = s_b;
  assign ci_in = s_ci;
`endif

  n_adder #(.N(N)) u_slice (
    .a   (a_reg[N-1:0]),
    .b   (b_reg[N-1:0]),
    .ci  (carry_reg),
    .sum (slice_sum),
    .co  (slice_co)
  );

  // Slice result enters at the top so that after K steps the LSB slice lands at bit 0.
  assign sum_shift = (sum_reg >> N) | (W'(slice_sum) << (W - N));

  assign accept = (state_reg == IDLE) && s_ready_reg && s_valid;
  assign step   = (state_reg == RUN);
  assign last   = step && (idx_reg == IW'(K - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)  state_next = RUN;
      RUN:     if (last)    state_next = DONE;
      DONE:    if (m_ready) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready_next = (state_next == IDLE);
    m_valid_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_ready_reg <= 1'b0;
      m_valid_reg <= 1'b0;
    end else begin
      s_ready_reg <= s_ready_next;
      m_valid_reg <= m_valid_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      a_sign_reg <= 1'b0;
      b_sign_reg <= 1'b0;
      m_co_reg   <= 1'b0;
      m_ovf_reg  <= 1'b0;
    end else if (accept) begin
      a_reg      <= s_a;
      b_reg      <= b_in;
      idx_reg    <= '0;
      carry_reg  <= ci_in;
      a_sign_reg <= s_a[W-1];
      b_sign_reg <= b_in[W-1];
    end else if (step) begin
      a_reg     <= a_reg >> N;
      b_reg     <= b_reg >> N;
      sum_reg   <= sum_shift;
      idx_reg   <= idx_reg + IW'(1);
      carry_reg <= slice_co;
      if (last) begin
        m_co_reg  <= slice_co;
        m_ovf_reg <= (a_sign_reg == b_sign_reg) && (slice_sum[N-1] != a_sign_reg);
      end
    end
  end

  assign s_ready = s_ready_reg;
  assign m_valid = m_valid_reg;
  assign m_sum   = sum_reg;
  assign m_co    = m_co_reg;
  assign m_ovf   = m_ovf_reg;
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed bench for multiword_add_ctrl (N=4, K=4): scoreboard of expected results, immediate assertions.
// Subtract steps are included when MWADD_SUB_EN is defined.

module tb_multiword_add_ctrl;
  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_a = '0;
  logic [W-1:0] s_b = '0;
  logic         s_ci = 1'b0;
`ifdef MWADD_SUB_EN
  logic         s_sub = 1'b0;
`endif
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_sum;
  logic         m_co;
  logic         m_ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  multiword_add_ctrl #(.N(N), .K(K)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .s_ci    (s_ci),
`ifdef MWADD_SUB_EN
    .s_sub   (s_sub),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sum   (m_sum),
    .m_co    (m_co),
    .m_ovf   (m_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge right after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic sub, input bit push, input string tag);
    logic [W-1:0] beff;
    logic         cin;
    logic [W:0]   r;
    exp_t         e;
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    beff = sub ? ~b : b;
    cin  = sub ? 1'b1 : ci;
    r    = {1'b0, a} + {1'b0, beff} + (W+1)'(cin);
    e.sum = r[W-1:0];
    e.co  = r[W];
    e.ovf = (a[W-1] == beff[W-1]) && (r[W-1] != a[W-1]);
    e.tag = tag;
    if (push) sb.push_back(e);
    s_a = a;
    s_b = b;
    s_ci = ci;
`ifdef MWADD_SUB_EN
    s_sub = sub;
`endif
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    s_a  = W'($urandom);
    s_b  = W'($urandom);
    s_ci = 1'($urandom);
    $display("[TB] sent %s a=%04h b=%04h ci=%0d sub=%0d", tag, a, b, ci, sub);
  endtask

  // Waits for m_valid, compares against the scoreboard, holds m_ready low for 'hold' cycles.
  task automatic collect(input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (m_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.tag, "_latency"}, 32'(lat), 32'(K));
    check({e.tag, "_sum"}, 32'(m_sum), 32'(e.sum));
    check({e.tag, "_co"},  32'(m_co),  32'(e.co));
    check({e.tag, "_ovf"}, 32'(m_ovf), 32'(e.ovf));
    $display("[TB] result %s sum=%04h co=%0d ovf=%0d lat=%0d", e.tag, m_sum, m_co, m_ovf, lat);
    for (int i = 0; i < hold; i++) begin
      s_valid = 1'b1;
      s_a = W'($urandom);
      s_b = W'($urandom);
      @(negedge clk);
      check({e.tag, "_bp_sum"},     32'(m_sum),   32'(e.sum));
      check({e.tag, "_bp_co"},      32'(m_co),    32'(e.co));
      check({e.tag, "_bp_ovf"},     32'(m_ovf),   32'(e.ovf));
      check({e.tag, "_bp_valid"},   32'(m_valid), 32'd1);
      check({e.tag, "_bp_s_ready"}, 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check({e.tag, "_drop_valid"}, 32'(m_valid), 32'd0);
    check({e.tag, "_s_ready_back"}, 32'(s_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_m_sum"},   32'(m_sum),   32'd0);
    check({tag, "_m_co"},    32'(m_co),    32'd0);
    check({tag, "_m_ovf"},   32'(m_ovf),   32'd0);
  endtask

  initial begin
    int seen;
    // Power-up reset
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rstn = 1'b1;
    @(negedge clk);
    check("por_rel_s_ready", 32'(s_ready), 32'd1);
    check("por_rel_m_valid", 32'(m_valid), 32'd0);

    send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, "add_1234_4321");
    collect(0);

    // Reset while idle with a non-zero result on the outputs
    rstn = 1'b0;
    #1;
    check_reset_outputs("idle_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_rst_rel_s_ready", 32'(s_ready), 32'd1);
    check("idle_rst_rel_m_valid", 32'(m_valid), 32'd0);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, "add_ffff_0001");
    collect(0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, "add_7fff_0001");
    collect(0);
    send(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, "add_0_0_ci");
    collect(0);

    // Backpressure: m_ready low for 3 cycles in DONE
    send(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b1, "bp_abcd_1111");
    collect(3);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, "add_8000_8000");
    collect(0);

    // Abort mid-RUN at idx=2
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, "abort_op");
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs("run_rst");
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < K + 2; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b0) seen++;
    end
    check("run_rst_no_valid", 32'(seen), 32'd0);
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, "add_0001_0001");
    collect(0);

`ifdef MWADD_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, "sub_0005_0007");
    collect(0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, "sub_8000_0001");
    collect(0);
    send(16'h1234, 16'h0034, 1'b1, 1'b0, 1'b1, "add_ci_sub0");
    collect(0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
